pulse_sample_sequencer: RTL and testbench
=========================================

# pulse_sample_sequencer

Schedules periodic sampling of the free-running PulseCounter channels (wheel encoders) and turns the raw counts into per-channel deltas. A programmable period timer or a software trigger starts a frame. Each frame snapshots all channels in the same cycle, then streams one delta per channel on a valid/ready port. It sits between the PulseCounter datapath and the AXI-Lite register/DMA consumer.

## Interface
- NUM_CH, 4, number of counter channels (2..16)
- CNT_W, 32, counter width of each channel
- DELTA_W, 16, output delta width (DELTA_W <= CNT_W)
- PERIOD_W, 24, period timer width
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- enable  in  1  level; sequencer armed while high
- cfg_period  in  PERIOD_W  sample period in ACLK cycles; 0 = timer off
- soft_trig  in  1  one-cycle manual frame request
- cnt_in  in  NUM_CH*CNT_W  live counter values, channel i at [i*CNT_W +: CNT_W]
- m_valid  out  1  delta beat valid
- m_ready  in  1  consumer ready
- m_ch  out  $clog2(NUM_CH)  channel index of beat
- m_delta  out  DELTA_W  channel delta
- m_last  out  1  beat is channel NUM_CH-1
- frame_done  out  1  one-cycle pulse after last beat accepted
- busy  out  1  high in any state but IDLE
- overrun  out  1  sticky: trigger arrived while busy
- overrun_clr  in  1  clears overrun

## Operation
- Reset: all outputs 0. State IDLE, timer 0, snapshot/prev registers 0, primed=0.
- Timer counts only while enable=1 and cfg_period!=0. Tick when timer >= cfg_period-1, then timer reloads 0. Lowering cfg_period below the current count ticks on the next cycle.
- Trigger = tick OR (soft_trig AND enable). A simultaneous tick and soft_trig make one trigger.
- FSM: IDLE -> CAPTURE on trigger. CAPTURE latches all cnt_in into snap[] in the same cycle.
  - If primed=0: prev[] <= cnt_in, primed <= 1, return to IDLE. No beats, no frame_done.
  - Else -> EMIT with ch=0.
- EMIT: m_valid=1, m_ch=ch, m_delta=fit(snap[ch]-prev[ch]), m_last=(ch==NUM_CH-1).
  - On m_valid&&m_ready: prev[ch] <= snap[ch] and ch++.
  - After the last beat is accepted -> DONE.
- Outputs hold stable while m_valid=1 and m_ready=0.
- DONE: frame_done=1 for one cycle -> IDLE.
- Delta arithmetic: subtraction modulo 2^CNT_W, so counter wrap is handled (prev=0xFFFFFFFE, snap=0x00000003 gives 5). The result is then fitted to DELTA_W (see Configuration).
- Trigger in any state but IDLE: dropped, overrun <= 1.
- overrun_clr and a new overrun in the same cycle: overrun stays 1.
- enable falling:
  - timer clears and primed clears;
  - a frame in progress completes normally;
  - the next enable rise requires a priming capture again.
- ARESETN assertion mid-frame: immediate return to reset values. No partial frame_done.

## Timing
- Trigger in cycle t (registered tick) -> CAPTURE at t+1 -> first m_valid at t+2.
- With m_ready held high: one beat per cycle. frame_done at t+2+NUM_CH. busy high from t+1 to t+2+NUM_CH inclusive.
- Earliest next accepted trigger: cycle t+3+NUM_CH.
- No combinational path from m_ready to m_valid, m_ch, m_delta or m_last.

## Configuration
- PULSE_SEQ_DELTA_SAT_EN defined: fit() saturates. If the modular difference exceeds 2^DELTA_W-1, m_delta = all ones.
- Not defined: fit() truncates to the low DELTA_W bits.
- When DELTA_W == CNT_W the two modes are identical.

## Structure
- Shared package pulse_seq_pkg holds:
  - the state enum (IDLE, CAPTURE, EMIT, DONE);
  - the fit() function (macro-dependent body);
  - the default parameter constants.
- One sub-module, pulse_seq_timer: period counter and tick generation, with enable/cfg_period/tick ports.
- FSM, snapshot/prev arrays and stream port stay in pulse_sample_sequencer.

## Test plan
- Priming: enable=1, cfg_period=100, cnt_in all 10 -> first tick gives no beats and no frame_done. At the second tick with ch0..3 = 15, 20, 10, 110 -> deltas 5, 10, 0, 100 with m_ch 0..3, m_last on ch3, frame_done two cycles after the last trigger + NUM_CH.
- Wrap: prev ch0=0xFFFFFFFE, snap ch0=0x00000003 -> m_delta=5.
- Large delta 0x12345: with PULSE_SEQ_DELTA_SAT_EN -> 0xFFFF; without -> 0x2345.
- Backpressure: m_ready low for 7 cycles on ch1 -> m_valid/m_ch/m_delta stable. A tick arriving meanwhile sets overrun=1. The frame still emits 4 beats. overrun_clr -> 0.
- Simultaneous soft_trig and tick -> exactly one frame of 4 beats, overrun stays 0.
- ARESETN low during EMIT at ch2 -> all outputs 0 next edge, no frame_done. After release, the first trigger is a priming capture.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared state type, default parameters and delta fitting for the pulse sample sequencer
// Contents: seq_state_t (IDLE, CAPTURE, EMIT, DONE), DEF_* parameter defaults, fit().
// Optional build macro: PULSE_SEQ_DELTA_SAT_EN (fit() saturates instead of truncating).
package pulse_seq_pkg;

    localparam int unsigned DEF_NUM_CH   = 4;
    localparam int unsigned DEF_CNT_W    = 32;
    localparam int unsigned DEF_DELTA_W  = 16;
    localparam int unsigned DEF_PERIOD_W = 24;

    // Working width for fit(); wide enough for any legal CNT_W.
    localparam int unsigned FIT_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

    // Reduce a modular counter difference to delta_w bits. A shift by the
    // full FIT_W yields zero, so delta_w == FIT_W still produces an all-ones mask.
    function automatic logic [FIT_W-1:0] fit(input logic [FIT_W-1:0] diff,
                                             input int unsigned      delta_w);
        logic [FIT_W-1:0] mask;
        mask = ~({FIT_W{1'b1}} << delta_w);
`ifdef PULSE_SEQ_DELTA_SAT_EN
        if ((diff & ~mask) != '0) begin
            return mask;
        end
        return diff;
`else
        return diff & mask;
`endif
    endfunction

endpackage

// File: rtl/pulse_sample_sequencer_if.sv
// rtl/pulse_sample_sequencer_if.sv - delta stream bundle between the sequencer and its consumer
// Signals: m_valid, m_ready, m_ch (channel index), m_delta (fitted delta), m_last (final channel).
// Modports: master (sequencer side), slave (consumer side).
interface pulse_sample_sequencer_if #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DELTA_W = 16
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic               m_valid;
    logic               m_ready;
    logic [CH_W-1:0]    m_ch;
    logic [DELTA_W-1:0] m_delta;
    logic               m_last;

    modport master (
        output m_valid,
        output m_ch,
        output m_delta,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_ch,
        input  m_delta,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/pulse_seq_timer.sv
// rtl/pulse_seq_timer.sv - sample period counter producing a registered one-cycle tick
// Ports: ACLK, ARESETN (async active-low), enable, cfg_period (0 = off), tick (out).
module pulse_seq_timer #(
    parameter int unsigned PERIOD_W = 24
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                tick
);
    logic [PERIOD_W-1:0] count;
    logic                running;

    assign running = enable && (cfg_period != '0);

    // ">=" rather than "==" so shrinking cfg_period below the current count
    // ticks on the next cycle instead of wrapping the whole counter range.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!running) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count >= (cfg_period - PERIOD_W'(1))) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + PERIOD_W'(1);
            tick  <= 1'b0;
        end
    end
endmodule

// File: rtl/pulse_sample_sequencer.sv
// rtl/pulse_sample_sequencer.sv - periodic snapshot of pulse counters streamed out as per-channel deltas
// Ports: ACLK, ARESETN (async active-low), enable, cfg_period, soft_trig, cnt_in (packed channels),
//        m (delta stream master), frame_done, busy, overrun (sticky), overrun_clr.
// Optional build macro: PULSE_SEQ_DELTA_SAT_EN (saturating delta fit).
module pulse_sample_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned DELTA_W  = DEF_DELTA_W,
    parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    enable,
    input  logic [PERIOD_W-1:0]     cfg_period,
    input  logic                    soft_trig,
    input  logic [NUM_CH*CNT_W-1:0] cnt_in,
    pulse_sample_sequencer_if.master m,
    output logic                    frame_done,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr
);
    localparam int unsigned     CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [CH_W-1:0]    ch;
    logic [CNT_W-1:0]   snap [NUM_CH];
    logic [CNT_W-1:0]   prev [NUM_CH];
    logic               primed;
    logic               tick;
    logic               trigger;
    logic               is_last;
    logic               beat_acc;
    logic [CNT_W-1:0]   diff;
    logic [FIT_W-1:0]   fitted;
    logic               out_valid;
    logic               out_last;
    logic               out_done;
    logic               out_busy;

    pulse_seq_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .enable     (enable),
        .cfg_period (cfg_period),
        .tick       (tick)
    );

    // A tick and a soft trigger in the same cycle collapse into one request.
    assign trigger  = tick | (soft_trig & enable);
    assign is_last  = (ch == LAST_CH);
    assign beat_acc = (state == EMIT) && m.m_ready;

    // Modular subtraction handles counter wrap for free.
    assign diff   = snap[ch] - prev[ch];
    assign fitted = fit(FIT_W'(diff), DELTA_W);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_done  = 1'b0;
        out_busy  = 1'b1;
        case (state)
            IDLE: begin
                out_busy = 1'b0;
                if (trigger) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // An unprimed capture only seeds prev[] and emits nothing.
                state_nxt = primed ? EMIT : IDLE;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = is_last;
                if (m.m_ready && is_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stream outputs depend only on registered state, never on m_ready.
    assign m.m_valid  = out_valid;
    assign m.m_last   = out_last;
    assign m.m_ch     = out_valid ? ch : '0;
    assign m.m_delta  = out_valid ? fitted[DELTA_W-1:0] : '0;
    assign frame_done = out_done;
    assign busy       = out_busy;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ch      <= '0;
            primed  <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i] <= '0;
                prev[i] <= '0;
            end
        end else begin
            if (state == CAPTURE) begin
                ch <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    snap[i] <= cnt_in[i*CNT_W +: CNT_W];
                    if (!primed) begin
                        prev[i] <= cnt_in[i*CNT_W +: CNT_W];
                    end
                end
            end else if (beat_acc) begin
                prev[ch] <= snap[ch];
                ch       <= is_last ? '0 : ch + CH_W'(1);
            end

            // Dropping enable forces a fresh priming capture after the next rise;
            // a frame already past CAPTURE runs to completion regardless.
            if (!enable) begin
                primed <= 1'b0;
            end else if ((state == CAPTURE) && !primed) begin
                primed <= 1'b1;
            end

            // A new overrun wins over a simultaneous clear.
            if (trigger && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pulse_sample_sequencer.sv
// tb/tb_pulse_sample_sequencer.sv - randomized self-checking bench for pulse_sample_sequencer
module tb_pulse_sample_sequencer;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 32;
    localparam int DELTA_W  = 16;
    localparam int PERIOD_W = 24;

    logic                    ACLK        = 1'b0;
    logic                    ARESETN     = 1'b0;
    logic                    enable      = 1'b0;
    logic                    soft_trig   = 1'b0;
    logic                    overrun_clr = 1'b0;
    logic [PERIOD_W-1:0]     cfg_period  = '0;
    logic [NUM_CH*CNT_W-1:0] cnt_in      = '0;
    logic                    frame_done;
    logic                    busy;
    logic                    overrun;

    int   ready_mode = 0;
    logic man_ready  = 1'b1;
    logic rnd_ready  = 1'b1;

    pulse_sample_sequencer_if #(.NUM_CH(NUM_CH), .DELTA_W(DELTA_W)) bus ();

    assign bus.m_ready = (ready_mode == 1) ? rnd_ready :
                         (ready_mode == 2) ? man_ready : 1'b1;

    pulse_sample_sequencer #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DELTA_W  (DELTA_W),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .enable      (enable),
        .cfg_period  (cfg_period),
        .soft_trig   (soft_trig),
        .cnt_in      (cnt_in),
        .m           (bus),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    always begin
        @(posedge ACLK);
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct {
        int          ch;
        logic [15:0] d;
        logic        last;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    fd_count = 0;
    int    fd_cyc   = 0;
    int    fd_base  = 0;

    logic        hold_v = 1'b0;
    logic [1:0]  hold_ch;
    logic [15:0] hold_d;
    logic        hold_last;

    // Beat collector plus stability check while the consumer stalls.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", bus.m_valid, 1);
                check("hold_ch", bus.m_ch, hold_ch);
                check("hold_delta", bus.m_delta, hold_d);
                check("hold_last", bus.m_last, hold_last);
            end
            if (bus.m_valid && bus.m_ready)
                got_q.push_back('{ch: int'(bus.m_ch), d: bus.m_delta, last: bus.m_last});
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
            hold_v    = bus.m_valid && !bus.m_ready;
            hold_ch   = bus.m_ch;
            hold_d    = bus.m_delta;
            hold_last = bus.m_last;
        end
    end

    // Reference model: per-frame deltas from the captured values.
    logic [31:0] cur    [NUM_CH];
    logic [31:0] m_prev [NUM_CH];
    bit          m_primed = 0;

    function automatic logic [15:0] fit_m(input longint unsigned d);
`ifdef PULSE_SEQ_DELTA_SAT_EN
        return (d > 65535) ? 16'hFFFF : 16'(d);
`else
        return 16'(d % 65536);
`endif
    endfunction

    task automatic model_capture();
        longint unsigned a, b, d;
        if (!m_primed) begin
            m_prev   = cur;
            m_primed = 1;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                a = cur[i];
                b = m_prev[i];
                d = (a + 64'h1_0000_0000 - b) % 64'h1_0000_0000;
                exp_q.push_back('{ch: i, d: fit_m(d), last: (i == NUM_CH - 1)});
                m_prev[i] = cur[i];
            end
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_cnt();
        for (int i = 0; i < NUM_CH; i++) cnt_in[i*CNT_W +: CNT_W] = cur[i];
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        if (busy) check({tag, "_idle_timeout"}, 0, 1);
    endtask

    task automatic wait_busy(input string tag, output int at);
        int k = 0;
        while (!busy && k < 300) begin
            step();
            k++;
        end
        if (!busy) check({tag, "_busy_timeout"}, 0, 1);
        at = cyc;
    endtask

    task automatic wait_beat(input string tag, input int ch_want);
        int k = 0;
        while (!(bus.m_valid && bus.m_ch == ch_want) && k < 50) begin
            step();
            k++;
        end
        if (!(bus.m_valid && bus.m_ch == ch_want)) check({tag, "_beat_timeout"}, 0, 1);
    endtask

    task automatic compare_frame(input string tag);
        int n;
        check({tag, "_nbeats"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ch%0d", tag, i), got_q[i].ch, exp_q[i].ch);
            check($sformatf("%s_delta%0d", tag, i), got_q[i].d, exp_q[i].d);
            check($sformatf("%s_last%0d", tag, i), got_q[i].last, exp_q[i].last);
        end
        check({tag, "_fdone"}, fd_count - fd_base, (exp_q.size() != 0) ? 1 : 0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic soft_frame(input string tag);
        drive_cnt();
        fd_base   = fd_count;
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        check({tag, "_busy"}, busy, 1);
        model_capture();
        wait_idle(tag);
        compare_frame(tag);
    endtask

    task automatic rand_cur(input bit allow_big);
        for (int i = 0; i < NUM_CH; i++)
            cur[i] = (allow_big && $urandom_range(0, 3) == 0) ? cur[i] + $urandom
                                                              : cur[i] + $urandom_range(0, 2000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b1, b2;
        for (int i = 0; i < NUM_CH; i++) cur[i] = 32'd10;
        repeat (3) step();
        check("rst_valid", bus.m_valid, 0);
        check("rst_ch", bus.m_ch, 0);
        check("rst_delta", bus.m_delta, 0);
        check("rst_last", bus.m_last, 0);
        check("rst_fdone", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        ARESETN = 1'b1;
        step();

        // soft_trig is ignored while disabled
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        check("trig_disabled_busy", busy, 0);

        // Timer-driven priming then first real frame
        drive_cnt();
        cfg_period = 100;
        enable     = 1'b1;
        fd_base    = fd_count;
        wait_busy("prime", b1);
        model_capture();
        wait_idle("prime");
        compare_frame("prime");
        cur[0] = 15; cur[1] = 20; cur[2] = 10; cur[3] = 110;
        drive_cnt();
        fd_base = fd_count;
        wait_busy("tick2", b2);
        check("tick_period", b2 - b1, 100);
        model_capture();
        wait_idle("tick2");
        check("busy_end_cycle", cyc, b2 + 2 + NUM_CH);
        compare_frame("tick2");
        check("fdone_cycle", fd_cyc, b2 + 1 + NUM_CH);
        cfg_period = 0;

        // Counter wrap and large delta
        rand_cur(0);
        cur[0] = 32'hFFFF_FFFE;
        soft_frame("wrap_pre");
        rand_cur(0);
        cur[0] = 32'h0000_0003;
        cur[1] = cur[1] + 32'h0001_2345;
        soft_frame("wrap_large");

        // Randomized frames with random consumer backpressure
        ready_mode = 1;
        for (int f = 0; f < 10; f++) begin
            rand_cur(1);
            soft_frame($sformatf("rand%0d", f));
        end
        ready_mode = 0;

        // Backpressure on ch1 with triggers arriving mid-frame
        ready_mode = 2;
        man_ready  = 1'b1;
        rand_cur(1);
        drive_cnt();
        fd_base   = fd_count;
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        model_capture();
        wait_beat("bp", 1);
        man_ready = 1'b0;
        check("bp_overrun_before", overrun, 0);
        for (int k = 0; k < 7; k++) begin
            soft_trig   = (k == 2 || k == 4);
            overrun_clr = (k == 4);
            step();
            soft_trig   = 1'b0;
            overrun_clr = 1'b0;
            if (k == 3) check("bp_overrun_set", overrun, 1);
            if (k == 4) check("bp_overrun_clr_vs_set", overrun, 1);
        end
        check("bp_beats_during_stall", got_q.size(), 1);
        man_ready = 1'b1;
        wait_idle("bp");
        compare_frame("bp");
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        check("bp_overrun_cleared", overrun, 0);
        ready_mode = 0;

        // Tick and soft_trig in the same cycle give a single frame
        rand_cur(0);
        drive_cnt();
        cfg_period = 30;
        fd_base    = fd_count;
        wait_busy("sim_first", b1);
        model_capture();
        wait_idle("sim_first");
        compare_frame("sim_first");
        rand_cur(0);
        drive_cnt();
        fd_base = fd_count;
        while (cyc < b1 + 29) step();
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        check("sim_busy", busy, 1);
        model_capture();
        wait_idle("sim");
        compare_frame("sim");
        check("sim_overrun", overrun, 0);
        cfg_period = 0;

        // Dropping enable requires a new priming capture
        enable = 1'b0;
        step();
        step();
        check("dis_busy", busy, 0);
        enable   = 1'b1;
        m_primed = 0;
        rand_cur(0);
        soft_frame("reprime");
        rand_cur(0);
        soft_frame("after_reprime");

        // Reset asserted while emitting ch2
        ready_mode = 2;
        man_ready  = 1'b1;
        rand_cur(0);
        drive_cnt();
        fd_base   = fd_count;
        soft_trig = 1'b1;
        step();
        soft_trig = 1'b0;
        wait_beat("rst_mid", 2);
        ARESETN = 1'b0;
        #1;
        check("rstmid_valid", bus.m_valid, 0);
        check("rstmid_ch", bus.m_ch, 0);
        check("rstmid_delta", bus.m_delta, 0);
        check("rstmid_last", bus.m_last, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_overrun", overrun, 0);
        step();
        step();
        check("rstmid_no_fdone", fd_count, fd_base);
        got_q.delete();
        exp_q.delete();
        m_primed = 0;
        ARESETN  = 1'b1;
        step();
        ready_mode = 0;
        rand_cur(0);
        soft_frame("post_rst_prime");
        rand_cur(1);
        soft_frame("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
